// File: rtl/regfile_pkg.sv
// Shared constants and the pending-write entry type for the register-file write path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package regfile_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/regfile_write_port_addr_decoder.sv
// Address to one-hot register select, gated by an enable.
// Latency: combinational.
// Backpressure: none; output is all zero while en is low.
module addr_decoder #(
  parameter int ADDR_W = 5,
  localparam int NREGS = 2 ** ADDR_W
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NREGS-1:0]  onehot
);

  assign onehot = en ? (NREGS'(1) << addr) : '0;

endmodule

// File: rtl/regfile_write_port.sv
// Write-side front end of the register file: pending-write FIFO, one-hot drain, read bypass.
// Latency: accept at edge N into empty FIFO -> wr_enable during cycle N+1, array captures at edge N+1.
// Backpressure: req_ready low while the FIFO is full; hold freezes the head but accepts continue.
module regfile_write_port #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  localparam int NREGS = 2 ** ADDR_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              hold,
  output logic [NREGS-1:0]  wr_enable,
  output logic [DATA_W-1:0] wr_data,
  output logic [CW-1:0]     pend_count,
  input  logic [ADDR_W-1:0] byp_addr_a,
  output logic              byp_hit_a,
  output logic [DATA_W-1:0] byp_data_a,
  input  logic [ADDR_W-1:0] byp_addr_b,
  output logic              byp_hit_b,
  output logic [DATA_W-1:0] byp_data_b
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count_q;
  logic              store;
  logic              drain;

  // Ready depends only on stored occupancy, so a same-cycle drain never frees a slot early.
  assign req_ready  = count_q < CW'(DEPTH);
  // r0 writes are acknowledged but never take a slot.
  assign store      = req_valid & req_ready & (req_addr != '0);
  assign drain      = (count_q != '0) & ~hold;
  assign pend_count = count_q;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PW'(1);
      if (drain) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(store) - CW'(drain);
    end
  end

  // Entry storage; contents are qualified by count_q so they need no reset.
  always_ff @(posedge clock) begin
    if (store) begin
      mem_addr[wr_ptr] <= req_addr;
      mem_data[wr_ptr] <= req_data;
    end
  end

  addr_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .en     (drain),
    .addr   (mem_addr[rd_ptr]),
    .onehot (wr_enable)
  );

  assign wr_data = drain ? mem_data[rd_ptr] : '0;

  // Walk entries oldest to youngest so the youngest match overwrites earlier ones.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    logic [PW-1:0]   idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count_q) && (a != '0) && (mem_addr[idx] == a))
        r = {1'b1, mem_data[idx]};
    end
    return r;
  endfunction

  assign {byp_hit_a, byp_data_a} = lookup(byp_addr_a);
  assign {byp_hit_b, byp_data_b} = lookup(byp_addr_b);

endmodule

// File: tb/tb_regfile_write_port.sv
// Randomized and directed bench for regfile_write_port against a queue-based reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_write_port;
  import regfile_pkg::*;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic        hold;
  logic [31:0] wr_enable;
  logic [31:0] wr_data;
  logic [1:0]  pend_count;
  logic [4:0]  byp_addr_a;
  logic        byp_hit_a;
  logic [31:0] byp_data_a;
  logic [4:0]  byp_addr_b;
  logic        byp_hit_b;
  logic [31:0] byp_data_b;

  int n_checks = 0;
  int n_errors = 0;

  // Pending writes in arrival order; front is the next to reach the array.
  wr_entry_t model_q[$];

  regfile_write_port #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .hold       (hold),
    .wr_enable  (wr_enable),
    .wr_data    (wr_data),
    .pend_count (pend_count),
    .byp_addr_a (byp_addr_a),
    .byp_hit_a  (byp_hit_a),
    .byp_data_a (byp_data_a),
    .byp_addr_b (byp_addr_b),
    .byp_hit_b  (byp_hit_b),
    .byp_data_b (byp_data_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to a nonzero address wins.
  function automatic logic [32:0] ref_byp(input logic [4:0] a);
    logic [32:0] r;
    r = '0;
    foreach (model_q[i])
      if (a != 0 && model_q[i].addr == a) r = {1'b1, model_q[i].data};
    return r;
  endfunction

  // Drive one cycle of inputs, compare settled outputs, then advance the model past the next edge.
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d, input logic h,
                      input logic [4:0] ba, input logic [4:0] bb);
    logic        exp_drain;
    logic        exp_acc;
    logic [32:0] ra;
    logic [32:0] rb;
    @(negedge clock);
    req_valid  = v;
    req_addr   = a;
    req_data   = d;
    hold       = h;
    byp_addr_a = ba;
    byp_addr_b = bb;
    #1;
    exp_drain = (model_q.size() > 0) && !h;
    exp_acc   = v && (model_q.size() < DEPTH);
    ra = ref_byp(ba);
    rb = ref_byp(bb);
    check("req_ready", req_ready, model_q.size() < DEPTH);
    check("pend_count", pend_count, model_q.size());
    check("wr_enable", wr_enable, exp_drain ? (64'd1 << model_q[0].addr) : 64'd0);
    check("wr_data", wr_data, exp_drain ? model_q[0].data : 32'd0);
    check("byp_a", {byp_hit_a, byp_data_a}, ra);
    check("byp_b", {byp_hit_b, byp_data_b}, rb);
    if (exp_drain) void'(model_q.pop_front());
    if (exp_acc && a != 0) model_q.push_back('{addr: a, data: d});
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 0; req_addr = 0; req_data = 0; hold = 0; byp_addr_a = 0; byp_addr_b = 0;
    #12;
    check("rst_wr_enable", wr_enable, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_pend_count", pend_count, 0);
    check("rst_byp_hit", {byp_hit_a, byp_hit_b}, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_release_ready", req_ready, 1);

    // Single write r5 into empty FIFO
    step(1, 5, 32'hDEADBEEF, 0, 5, 0);
    step(0, 0, 0, 0, 5, 0);
    check("r5_enable", wr_enable, 32'h0000_0020);
    check("r5_data", wr_data, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0);

    // r0 write is accepted but never stored
    step(1, 0, 32'h12345678, 0, 0, 0);
    check("r0_ready", req_ready, 1);
    step(0, 0, 0, 0, 0, 0);
    check("r0_count", pend_count, 0);
    check("r0_enable", wr_enable, 0);

    // Duplicate address under hold, youngest forwarded, drained in order
    step(1, 3, 32'hA, 1, 0, 0);
    step(1, 3, 32'hB, 1, 0, 0);
    step(0, 0, 0, 1, 3, 3);
    check("hold_ready", req_ready, 0);
    check("hold_count", pend_count, 2);
    check("hold_byp", {byp_hit_a, byp_data_a}, {1'b1, 32'hB});
    step(0, 0, 0, 0, 3, 0);
    check("hold_drain1", {wr_enable, wr_data}, {32'h8, 32'hA});
    step(0, 0, 0, 0, 3, 0);
    check("hold_drain2", {wr_enable, wr_data}, {32'h8, 32'hB});

    // Back-to-back stream at full throughput
    for (int i = 1; i <= 8; i++) begin
      step(1, 5'(i), 32'h100 + 32'(i), 0, 5'(i), 5'(i - 1));
      check("b2b_ready", req_ready, 1);
      check("b2b_count_le1", pend_count <= 2'd1, 1);
      if (i > 1) check("b2b_order", wr_enable, 32'd1 << (i - 1));
    end
    step(0, 0, 0, 0, 0, 0);
    check("b2b_last", wr_enable, 32'h100);

    // Full FIFO, one drain cycle, accept only on the following cycle
    step(1, 10, 32'hAA, 1, 0, 0);
    step(1, 11, 32'hBB, 1, 0, 0);
    step(1, 12, 32'hCC, 0, 11, 12);
    check("full_count2", pend_count, 2);
    check("full_no_ready", req_ready, 0);
    step(1, 12, 32'hCC, 1, 12, 0);
    check("full_count1", pend_count, 1);
    step(0, 0, 0, 1, 12, 11);
    check("full_count2b", pend_count, 2);

    // Asynchronous reset mid-traffic drops pending writes at once
    step(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    req_valid = 0; hold = 0; byp_addr_a = 12; byp_addr_b = 11;
    #2 reset = 1'b0;
    #1;
    check("midrst_enable", wr_enable, 0);
    check("midrst_count", pend_count, 0);
    check("midrst_hit", {byp_hit_a, byp_hit_b}, 0);
    model_q.delete();
    @(negedge clock);
    reset = 1'b1;

    // Random traffic over a small address range for frequent bypass hits
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    check("drained_empty", pend_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
